// File: rtl/rt_tx_device_pkg.sv
// Shared definitions for the MKIO remote-terminal transmit and receive devices.
// Contents: responder state encoding, status-word field positions, the sync-type
// codes driven on tx_cd, and a helper that assembles a status word.
package rt_tx_device_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_OS   = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4,
        ST_FETCH     = 3'd5,
        ST_LATCH     = 3'd6,
        ST_END       = 3'd7
    } rt_state_e;

    // Status word layout: terminal address in the top five bits, message
    // error flag right below it, all other flags zero.
    localparam int STAT_ADDR_MSB = 15;
    localparam int STAT_ADDR_LSB = 11;
    localparam int STAT_ERR_BIT  = 10;

    localparam logic CD_CMD_SYNC  = 1'b0;
    localparam logic CD_DATA_SYNC = 1'b1;

    function automatic logic [15:0] make_status(input logic [4:0] addr, input logic err);
        logic [15:0] w;
        w = '0;
        w[STAT_ADDR_MSB:STAT_ADDR_LSB] = addr;
        w[STAT_ERR_BIT] = err;
        return w;
    endfunction

endpackage

// File: rtl/rt_tx_buffer.sv
// 32x16 simple dual-port buffer for the transmit subaddress.
// One clock, one write port, one read port with a registered output
// (rd_data shows mem[rd_addr] one clock after rd_addr is presented).
// Ports:
//   clk      system clock
//   wr_en    write strobe, already gated by the parent
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  registered read data
module rt_tx_buffer (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [4:0]  rd_addr,
    output logic [15:0] rd_data
);

    logic [15:0] mem [32];

    // No reset: buffer contents survive a link reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rt_tx_device.sv
// MKIO remote-terminal transmit-subaddress responder.
// On start it sends the status word, then buffer[0..N-1] (N = cmd_word[4:0],
// 0 meaning 32) to the channel encoder, one word per tx_ready/tx_busy handshake.
// Ports:
//   clk, reset           system clock, asynchronous active-low reset
//   start, cmd_word      decoded transmit command for this terminal
//   cmd_error            command parity/format error, sampled with start
//   wr_en/addr/data      host buffer write port, ignored while busy
//   tx_data, tx_cd       word and sync type to the encoder
//   tx_ready             word-valid strobe to the encoder
//   tx_busy              encoder serialising a word
//   busy                 message in progress
//   done, timeout_err    one-clock completion / encoder-timeout pulses
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start, host may write the buffer
// LOAD_OS    | load status word into tx_data, rewind read address
// SEND       | hold tx_ready high for READY_CYCLES clocks
// WAIT_RISE  | wait for encoder to go busy, bounded by BUSY_TIMEOUT
// WAIT_FALL  | wait for encoder to finish the word
// FETCH      | present read address to the buffer
// LATCH      | capture buffer output as the next data word
// END        | pulse done, back to IDLE
module rt_tx_device
    import rt_tx_device_pkg::*;
#(
    parameter logic [4:0] ADDRESS      = 5'd1,
    parameter int         READY_CYCLES = 3,
    parameter logic [7:0] BUSY_TIMEOUT = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] cmd_word,
    input  logic        cmd_error,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    output logic        tx_ready,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam logic [7:0] READY_LOAD = 8'(READY_CYCLES - 1);

    rt_state_e   state, state_nxt;
    logic [4:0]  last_idx;
    logic        err_bit;
    logic [4:0]  rd_addr;
    logic [4:0]  word_idx;
    logic [7:0]  ready_cnt;
    logic [7:0]  tmo_cnt;
    logic [15:0] rd_data;
    logic        ready_tc;
    logic        tmo_tc;
    logic        last_word;
    logic        unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_word[15:5];

    assign ready_tc  = (ready_cnt == 8'd0);
    assign tmo_tc    = (tmo_cnt == 8'd0);
    // The status word goes out with command sync, so it never ends a message.
    assign last_word = (tx_cd == CD_DATA_SYNC) && (word_idx == last_idx);

    rt_tx_buffer u_buffer (
        .clk     (clk),
        .wr_en   (wr_en & ~busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_LOAD_OS;
                end
            end
            ST_LOAD_OS: state_nxt = ST_SEND;
            ST_SEND: begin
                tx_ready = 1'b1;
                if (ready_tc) begin
                    state_nxt = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_FALL;
                end else if (tmo_tc) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_FALL: begin
                if (!tx_busy) begin
                    state_nxt = last_word ? ST_END : ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_SEND;
            ST_END: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data     <= '0;
            tx_cd       <= CD_CMD_SYNC;
            timeout_err <= 1'b0;
            last_idx    <= '0;
            err_bit     <= 1'b0;
            rd_addr     <= '0;
            word_idx    <= '0;
            ready_cnt   <= '0;
            tmo_cnt     <= '0;
        end else begin
            timeout_err <= (state == ST_WAIT_RISE) && !tx_busy && tmo_tc;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // N of 0 means 32 words; the 5-bit wrap gives 31.
                        last_idx <= cmd_word[4:0] - 5'd1;
                        err_bit  <= cmd_error;
                    end
                end
                ST_LOAD_OS: begin
                    tx_data   <= make_status(ADDRESS, err_bit);
                    tx_cd     <= CD_CMD_SYNC;
                    rd_addr   <= '0;
                    word_idx  <= '0;
                    ready_cnt <= READY_LOAD;
                end
                ST_SEND: begin
                    if (!ready_tc) begin
                        ready_cnt <= ready_cnt - 8'd1;
                    end else begin
                        tmo_cnt <= BUSY_TIMEOUT - 8'd1;
                    end
                end
                ST_WAIT_RISE: begin
                    if (!tx_busy && !tmo_tc) begin
                        tmo_cnt <= tmo_cnt - 8'd1;
                    end
                end
                ST_LATCH: begin
                    tx_data   <= rd_data;
                    tx_cd     <= CD_DATA_SYNC;
                    word_idx  <= rd_addr;
                    rd_addr   <= rd_addr + 5'd1;
                    ready_cnt <= READY_LOAD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rt_tx_device.sv
module tb_rt_tx_device;

    localparam int TB_ADDRESS = 1;
    localparam int TB_READY   = 3;
    localparam int TB_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cmd_word = '0;
    logic        cmd_error = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        tx_busy = 1'b0;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        timeout_err;

    rt_tx_device dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cmd_word    (cmd_word),
        .cmd_error   (cmd_error),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .tx_data     (tx_data),
        .tx_cd       (tx_cd),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    // Reference model: buffer image plus queues of expected wire words
    // ({cd, data}) and expected message endings (0 = done, 1 = timeout).
    logic [15:0] mdl_buf [32];
    logic [16:0] exp_words [$];
    bit          exp_end [$];
    int          words_seen = 0;

    bit enc_en  = 1'b1;
    int enc_dly = 2;
    int enc_len = 20;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Encoder model: some clocks after seeing tx_ready, go busy for a while.
    initial forever begin
        @(posedge clk);
        #1;
        if (reset && enc_en && tx_ready && !tx_busy) begin
            repeat (enc_dly) begin @(posedge clk); #1; end
            tx_busy = 1'b1;
            repeat (enc_len) begin @(posedge clk); #1; end
            tx_busy = 1'b0;
        end
    end

    // Monitor / scoreboard.
    logic        prev_ready = 1'b0;
    logic        prev_busy = 1'b0;
    int          ready_len = 0;
    logic [16:0] held = '0;
    int unsigned fall_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            prev_ready = 1'b0;
            prev_busy  = 1'b0;
            ready_len  = 0;
        end else begin
            if (tx_ready && !prev_ready) begin
                words_seen++;
                if (exp_words.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h, required no word", {tx_cd, tx_data});
                end else begin
                    check("word", {15'd0, tx_cd, tx_data}, {15'd0, exp_words.pop_front()});
                end
                held = {tx_cd, tx_data};
                ready_len = 1;
            end else if (tx_ready) begin
                ready_len++;
                check("word_stable", {15'd0, tx_cd, tx_data}, {15'd0, held});
            end
            if (!tx_ready && prev_ready) begin
                check("ready_len", ready_len, TB_READY);
                fall_cyc = cyc;
            end
            if (done || timeout_err) begin
                if (exp_end.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end: got done=%0b timeout_err=%0b, required none", done, timeout_err);
                end else begin
                    check("end_kind", {30'd0, done, timeout_err}, exp_end.pop_front() ? 32'd1 : 32'd2);
                end
                check("busy_at_end", {31'd0, busy}, 32'd0);
                check("words_left", exp_words.size(), 0);
                if (done) check("busy_before_done", {31'd0, prev_busy}, 32'd1);
                if (timeout_err) check("timeout_delay", cyc - fall_cyc, TB_TIMEOUT);
            end
            prev_ready = tx_ready;
            prev_busy  = busy;
        end
    end

    task automatic host_write(input int a, input logic [15:0] d, input bit accepted);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[4:0];
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (accepted) mdl_buf[a] = d;
    endtask

    task automatic issue_cmd(input logic [15:0] cmd, input logic err, input bit expect_timeout);
        int n;
        logic [15:0] st;
        n  = (cmd[4:0] == 5'd0) ? 32 : int'(cmd[4:0]);
        st = 16'(TB_ADDRESS * 2048 + (err ? 1024 : 0));
        exp_words.push_back({1'b0, st});
        if (!expect_timeout) begin
            for (int i = 0; i < n; i++) exp_words.push_back({1'b1, mdl_buf[i]});
        end
        exp_end.push_back(expect_timeout);
        @(negedge clk);
        start     = 1'b1;
        cmd_word  = cmd;
        cmd_error = err;
        @(negedge clk);
        start     = 1'b0;
        cmd_error = 1'b0;
    endtask

    task automatic wait_msg(input int budget);
        int k;
        k = 0;
        while (exp_end.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("msg_complete", exp_end.size(), 0);
        exp_end.delete();
        exp_words.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_data"}, {16'd0, tx_data}, 32'd0);
        check({tag, "_tx_cd"}, {31'd0, tx_cd}, 32'd0);
        check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        logic [15:0] r;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 32; i++) host_write(i, 16'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) host_write(i, 16'hA000 + 16'(i), 1'b1);

        // Basic four-word message, fixed encoder timing.
        enc_dly = 2;
        enc_len = 20;
        issue_cmd(16'h0004, 1'b0, 1'b0);
        wait_msg(2000);

        // Error flag set, N field 0 -> 32 words.
        r = 16'($urandom);
        issue_cmd({r[15:5], 5'd0}, 1'b1, 1'b0);
        wait_msg(4000);

        // Encoder never answers.
        enc_en = 1'b0;
        issue_cmd(16'h0003, 1'b0, 1'b1);
        wait_msg(500);
        enc_en = 1'b1;

        // Write lockout and ignored restart.
        host_write(1, 16'h1234, 1'b1);
        enc_len = 10;
        base = words_seen;
        issue_cmd(16'h0004, 1'b0, 1'b0);
        k = 0;
        while (words_seen < base + 2 && k < 300) begin @(negedge clk); k++; end
        check("lockout_reached", {31'd0, busy}, 32'd1);
        host_write(1, 16'hFFFF, 1'b0);
        @(negedge clk);
        start    = 1'b1;
        cmd_word = 16'h0007;
        @(negedge clk);
        start = 1'b0;
        wait_msg(2000);
        issue_cmd(16'h0002, 1'b0, 1'b0);
        wait_msg(1000);

        // Reset during the third data word.
        base = words_seen;
        issue_cmd(16'h0006, 1'b0, 1'b0);
        k = 0;
        while (words_seen < base + 4 && k < 500) begin @(negedge clk); k++; end
        check("reset_point", {31'd0, tx_ready}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_end.delete();
        exp_words.delete();
        repeat (30) @(negedge clk);
        reset = 1'b1;
        issue_cmd(16'h0003, 1'b0, 1'b0);
        wait_msg(1000);

        // Randomized messages.
        for (int m = 0; m < 8; m++) begin
            for (int j = 0; j < 3; j++) host_write($urandom_range(0, 31), 16'($urandom), 1'b1);
            enc_dly = $urandom_range(0, 6);
            enc_len = $urandom_range(4, 20);
            r = 16'($urandom);
            issue_cmd({r[15:5], 5'($urandom_range(1, 10))}, 1'($urandom_range(0, 1)), 1'b0);
            wait_msg(2000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
